mc_switch_alloc: RTL and testbench

- Parametrised multicast connection allocator for the N-port switch crossbar.
- Generalises the 4-port all-or-nothing arbiter:
  - port count is parametrised;
  - a connection is held across a multi-beat packet until end-of-packet;
  - per-output ownership state is kept;
  - a starvation guard reserves outputs for inputs that have waited too long.
- Sits between the input port FIFOs and the crossbar output muxes.

---
 rtl/mc_switch_alloc.sv | 201 ++++++++++++++++++++
 tb/tb_mc_switch_alloc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_switch_alloc.sv
// Multicast connection allocator for an N-port crossbar.
// Grants an input all of its requested outputs at once (all-or-nothing),
// holds the connection until end-of-packet, arbitrates each free output
// round-robin, and lets a long-waiting input reserve outputs so it cannot
// be starved by a stream of smaller packets.
module mc_switch_alloc #(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = $clog2(NUM_PORTS),
  parameter int MAX_WAIT  = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] dst,
  input  logic [NUM_PORTS-1:0]         eop,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [NUM_PORTS*SEL_W-1:0]   mux_sel,
  output logic [NUM_PORTS-1:0]         active,
  output logic [NUM_PORTS-1:0]         urgent
);

  localparam int WAIT_W = 8;

  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [NUM_PORTS-1:0] active_q, active_d;
  logic [NUM_PORTS-1:0] urgent_q, urgent_d;
  logic [NUM_PORTS-1:0] mask_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] mask_d [NUM_PORTS];
  logic [SEL_W-1:0]     sel_q  [NUM_PORTS];
  logic [SEL_W-1:0]     sel_d  [NUM_PORTS];
  logic [SEL_W-1:0]     ptr_q  [NUM_PORTS];
  logic [SEL_W-1:0]     ptr_d  [NUM_PORTS];
  logic [WAIT_W-1:0]    wait_q [NUM_PORTS];
  logic [WAIT_W-1:0]    wait_d [NUM_PORTS];

  logic [NUM_PORTS-1:0] dst_m    [NUM_PORTS];
  logic [NUM_PORTS-1:0] cand_s;
  logic                 urg_found_s;
  logic [SEL_W-1:0]     urg_idx_s;
  logic [NUM_PORTS-1:0] reserved_s;
  logic [NUM_PORTS-1:0] lwin_vld_s;
  logic [SEL_W-1:0]     lwin_idx_s [NUM_PORTS];
  logic [NUM_PORTS-1:0] win_s;

  // Unpack the flat destination bus into one mask per input.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      dst_m[i] = dst[i*NUM_PORTS +: NUM_PORTS];
    end
  end

  // Candidates, and the lowest-index urgent candidate with its reservation.
  always_comb begin
    cand_s      = '0;
    urg_found_s = 1'b0;
    urg_idx_s   = '0;
    reserved_s  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand_s[i] = req[i] & ~grant_q[i] & (dst_m[i] != '0);
      if (cand_s[i] && urgent_q[i]) begin
        urg_found_s = 1'b1;
        urg_idx_s   = SEL_W'(i);
      end else begin
        urg_found_s = urg_found_s;
      end
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      reserved_s[o] = urg_found_s & ~active_q[o] & dst_m[urg_idx_s][o];
    end
  end

  // Round-robin pick per free, unreserved output, starting at ptr and wrapping.
  always_comb begin
    int c;
    c          = 0;
    lwin_vld_s = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      lwin_idx_s[o] = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        c = int'(ptr_q[o]) + k;
        if (c >= NUM_PORTS) begin
          c = c - NUM_PORTS;
        end else begin
          c = c;
        end
        if (!lwin_vld_s[o] && !active_q[o] && !reserved_s[o] &&
            cand_s[c] && dst_m[c][o]) begin
          lwin_vld_s[o] = 1'b1;
          lwin_idx_s[o] = SEL_W'(c);
        end else begin
          lwin_vld_s[o] = lwin_vld_s[o];
        end
      end
    end
  end

  // All-or-nothing: an input wins only if every output in its mask is free
  // and was won locally or reserved by it.
  always_comb begin
    win_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      win_s[i] = cand_s[i];
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (dst_m[i][o] && !(!active_q[o] &&
            ((reserved_s[o] && urg_idx_s == SEL_W'(i)) ||
             (!reserved_s[o] && lwin_vld_s[o] && lwin_idx_s[o] == SEL_W'(i))))) begin
          win_s[i] = 1'b0;
        end else begin
          win_s[i] = win_s[i];
        end
      end
    end
  end

  // Next state: releases on eop, new connections on wins, pointers and wait counters.
  always_comb begin
    grant_d  = grant_q;
    active_d = active_q;
    urgent_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      mask_d[i] = mask_q[i];
      sel_d[i]  = sel_q[i];
      ptr_d[i]  = ptr_q[i];
      wait_d[i] = wait_q[i];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i] && eop[i]) begin
        grant_d[i] = 1'b0;
        mask_d[i]  = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
          if (mask_q[i][o]) begin
            active_d[o] = 1'b0;
            sel_d[o]    = '0;
          end else begin
            active_d[o] = active_d[o];
          end
        end
      end else if (win_s[i]) begin
        grant_d[i] = 1'b1;
        mask_d[i]  = dst_m[i];
        for (int o = 0; o < NUM_PORTS; o++) begin
          if (dst_m[i][o]) begin
            active_d[o] = 1'b1;
            sel_d[o]    = SEL_W'(i);
            ptr_d[o]    = SEL_W'((i + 1) % NUM_PORTS);
          end else begin
            active_d[o] = active_d[o];
          end
        end
      end else begin
        grant_d[i] = grant_d[i];
      end
      if (win_s[i]) begin
        wait_d[i] = '0;
      end else if (cand_s[i] && wait_q[i] != WAIT_W'(MAX_WAIT)) begin
        wait_d[i] = wait_q[i] + 8'd1;
      end else begin
        wait_d[i] = wait_q[i];
      end
      urgent_d[i] = (wait_d[i] == WAIT_W'(MAX_WAIT));
    end
  end

  // State registers; reset drops every connection immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      active_q <= '0;
      urgent_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        mask_q[i] <= '0;
        sel_q[i]  <= '0;
        ptr_q[i]  <= '0;
        wait_q[i] <= '0;
      end
    end else begin
      grant_q  <= grant_d;
      active_q <= active_d;
      urgent_q <= urgent_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        mask_q[i] <= mask_d[i];
        sel_q[i]  <= sel_d[i];
        ptr_q[i]  <= ptr_d[i];
        wait_q[i] <= wait_d[i];
      end
    end
  end

  // Pack per-output selects onto the flat mux_sel bus.
  always_comb begin
    mux_sel = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      mux_sel[o*SEL_W +: SEL_W] = sel_q[o];
    end
  end

  assign grant  = grant_q;
  assign active = active_q;
  assign urgent = urgent_q;

endmodule

// File: tb/tb_mc_switch_alloc.sv
// Directed bench for mc_switch_alloc: three instances (4 ports / wait 15,
// 4 ports / wait 3, 5 ports / wait 15) driven by one linear sequence.
module tb_mc_switch_alloc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Instance A: 4 ports, MAX_WAIT 15
  logic [3:0]  a_req, a_eop, a_grant, a_active, a_urgent;
  logic [15:0] a_dst;
  logic [7:0]  a_sel;
  // Instance B: 4 ports, MAX_WAIT 3
  logic [3:0]  b_req, b_eop, b_grant, b_active, b_urgent;
  logic [15:0] b_dst;
  logic [7:0]  b_sel;
  // Instance C: 5 ports, MAX_WAIT 15
  logic [4:0]  c_req, c_eop, c_grant, c_active, c_urgent;
  logic [24:0] c_dst;
  logic [14:0] c_sel;

  mc_switch_alloc #(.NUM_PORTS(4), .SEL_W(2), .MAX_WAIT(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .dst(a_dst), .eop(a_eop),
    .grant(a_grant), .mux_sel(a_sel), .active(a_active), .urgent(a_urgent));

  mc_switch_alloc #(.NUM_PORTS(4), .SEL_W(2), .MAX_WAIT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .dst(b_dst), .eop(b_eop),
    .grant(b_grant), .mux_sel(b_sel), .active(b_active), .urgent(b_urgent));

  mc_switch_alloc #(.NUM_PORTS(5), .SEL_W(3), .MAX_WAIT(15)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(c_req), .dst(c_dst), .eop(c_eop),
    .grant(c_grant), .mux_sel(c_sel), .active(c_active), .urgent(c_urgent));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = '0; a_eop = '0; a_dst = '0;
    b_req = '0; b_eop = '0; b_dst = '0;
    c_req = '0; c_eop = '0; c_dst = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_g [9];
  logic [7:0] exp_s [9];

  initial begin
    exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    exp_s = '{8'h00,   8'h00,   8'h10,   8'h00,   8'h20,   8'h00,   8'h30,   8'h00,   8'h00};

    // ---- Reset state ----
    do_reset();
    chk("rst_grant",  32'(a_grant),  32'h0);
    chk("rst_active", 32'(a_active), 32'h0);
    chk("rst_sel",    32'(a_sel),    32'h0);
    chk("rst_urgent", 32'(a_urgent), 32'h0);

    // ---- Basic multicast connection held until eop ----
    a_req = 4'b0001;
    a_dst[3:0] = 4'b0110;
    tick();
    chk("t1_grant",  32'(a_grant),  32'h1);
    chk("t1_active", 32'(a_active), 32'h6);
    chk("t1_sel",    32'(a_sel),    32'h0);
    a_dst[3:0] = 4'b1001;  // ignored while connected
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_hold_grant",  32'(a_grant),  32'h1);
      chk("t1_hold_active", 32'(a_active), 32'h6);
    end
    a_eop = 4'b0001;
    a_req = 4'b0000;
    tick();
    a_eop = 4'b0000;
    chk("t1_rel_grant",  32'(a_grant),  32'h0);
    chk("t1_rel_active", 32'(a_active), 32'h0);

    // ---- Round robin of single-beat packets on output 2 ----
    do_reset();
    a_req = 4'b1111;
    a_eop = 4'b1111;
    a_dst = {4{4'b0100}};
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("t2_grant", 32'(a_grant), 32'(exp_g[k]));
      chk("t2_sel",   32'(a_sel),   32'(exp_s[k]));
    end

    // ---- All-or-nothing: partial availability does not connect ----
    do_reset();
    a_req = 4'b0001;
    a_dst[3:0] = 4'b0010;
    tick();
    chk("t3_grant0", 32'(a_grant), 32'h1);
    a_req = 4'b0011;
    a_dst[7:4] = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_wait_grant",  32'(a_grant),  32'h1);
      chk("t3_wait_active", 32'(a_active), 32'h2);
    end
    a_eop = 4'b0001;
    a_req = 4'b0010;
    tick();
    a_eop = 4'b0000;
    chk("t3_rel_grant",  32'(a_grant),  32'h0);
    chk("t3_rel_active", 32'(a_active), 32'h0);
    tick();
    chk("t3_g1_grant",  32'(a_grant),  32'h2);
    chk("t3_g1_active", 32'(a_active), 32'ha);
    chk("t3_g1_sel",    32'(a_sel),    32'h44);

    // ---- Starvation guard (MAX_WAIT = 3) ----
    do_reset();
    b_dst[3:0]   = 4'b0011;
    b_dst[7:4]   = 4'b0011;
    b_dst[15:12] = 4'b1111;
    b_req = 4'b1011;
    b_eop = 4'b1111;
    tick();
    chk("t4_e1_grant",  32'(b_grant),  32'h1);
    chk("t4_e1_urgent", 32'(b_urgent), 32'h0);
    tick();
    chk("t4_e2_grant",  32'(b_grant),  32'h0);
    tick();
    chk("t4_e3_grant",  32'(b_grant),  32'h2);
    chk("t4_e3_urgent", 32'(b_urgent), 32'h8);
    tick();
    chk("t4_e4_grant",  32'(b_grant),  32'h0);
    chk("t4_e4_active", 32'(b_active), 32'h0);
    chk("t4_e4_urgent", 32'(b_urgent), 32'h8);
    tick();
    chk("t4_e5_grant",  32'(b_grant),  32'h8);
    chk("t4_e5_active", 32'(b_active), 32'hf);
    chk("t4_e5_sel",    32'(b_sel),    32'hff);
    chk("t4_e5_urgent", 32'(b_urgent), 32'h1);

    // ---- Five ports: pointer wrap from 4 to 0 ----
    do_reset();
    c_req = 5'b01000;
    c_dst[15 +: 5] = 5'b10000;
    c_eop = 5'b11111;
    tick();
    chk("t5_g3_grant", 32'(c_grant), 32'h08);
    c_req = 5'b10001;
    c_dst[0 +: 5]  = 5'b10000;
    c_dst[20 +: 5] = 5'b10000;
    tick();
    chk("t5_rel_grant", 32'(c_grant), 32'h00);
    tick();
    chk("t5_g4_grant", 32'(c_grant), 32'h10);
    chk("t5_g4_sel",   32'(c_sel),   32'h4000);
    tick();
    chk("t5_rel2_grant", 32'(c_grant), 32'h00);
    tick();
    chk("t5_g0_grant",  32'(c_grant),  32'h01);
    chk("t5_g0_active", 32'(c_active), 32'h10);
    chk("t5_g0_sel",    32'(c_sel),    32'h0);

    // ---- Async reset mid-packet, then arbitration restarts at ptr 0 ----
    do_reset();
    a_req = 4'b0101;
    a_dst = {4'b0000, 4'b0100, 4'b0000, 4'b0001};
    tick();
    chk("t6_pre_grant",  32'(a_grant),  32'h5);
    chk("t6_pre_active", 32'(a_active), 32'h5);
    chk("t6_pre_sel",    32'(a_sel),    32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant",  32'(a_grant),  32'h0);
    chk("t6_rst_active", 32'(a_active), 32'h0);
    chk("t6_rst_sel",    32'(a_sel),    32'h0);
    chk("t6_rst_urgent", 32'(a_urgent), 32'h0);
    a_req = 4'b0011;
    a_dst = {4'b0000, 4'b0000, 4'b0001, 4'b0001};
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_grant",  32'(a_grant),  32'h1);
    chk("t6_post_active", 32'(a_active), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
